// File: rtl/bram_rd_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_REQ requesters; routes each
// read word back to its issuer two cycles after grant. Optional write-to-read forwarding: BRAM_RD_WR_FWD_EN.
module bram_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 192
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [NUM_REQ-1:0]            rsp_vld,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy,
    input  logic                          wr_vld,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          bram_re,
    output logic [ADDR_WIDTH-1:0]         bram_rd_addr,
    input  logic [DATA_WIDTH-1:0]         bram_rd_data,
    output logic                          bram_we,
    output logic [ADDR_WIDTH-1:0]         bram_wr_addr,
    output logic [DATA_WIDTH-1:0]         bram_wr_data
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TAG_W-1:0] PTR_INIT = TAG_W'(NUM_REQ - 1);

    logic [TAG_W-1:0]      ptr_reg;
    logic [TAG_W-1:0]      gnt_idx;
    logic                  grant;
    logic                  s1_vld_reg;
    logic [TAG_W-1:0]      s1_tag_reg;
    logic [NUM_REQ-1:0]    rsp_vld_reg;
    logic [NUM_REQ-1:0]    rsp_vld_next;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]     = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_rdy[gi]      = grant && (gnt_idx == TAG_W'(gi));
            assign rsp_vld_next[gi] = s1_vld_reg && (s1_tag_reg == TAG_W'(gi));
        end
    endgenerate

    // Search starts one past the last winner so every active requester is served in turn.
    always_comb begin
        int idx;
        grant   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_reg) + k) % NUM_REQ;
            if (!grant && req_vld[idx[TAG_W-1:0]]) begin
                grant   = 1'b1;
                gnt_idx = idx[TAG_W-1:0];
            end
        end
        if (!arb_en || !rst_n) begin
            grant   = 1'b0;
            gnt_idx = '0;
        end
    end

    assign bram_re      = grant;
    assign bram_rd_addr = grant ? addr_arr[gnt_idx] : '0;

    assign bram_we      = wr_vld;
    assign bram_wr_addr = wr_addr;
    assign bram_wr_data = wr_data;

`ifdef BRAM_RD_WR_FWD_EN
    // A same-cycle write to the granted address overrides the BRAM's read-first word.
    logic                  fwd_reg;
    logic [DATA_WIDTH-1:0] fwd_data_reg;
    logic                  fwd_hit;

    assign fwd_hit = grant && wr_vld && (wr_addr == bram_rd_addr);
    assign rd_word = fwd_reg ? fwd_data_reg : bram_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_reg      <= 1'b0;
            fwd_data_reg <= '0;
        end else begin
            fwd_reg <= fwd_hit;
            if (fwd_hit) begin
                fwd_data_reg <= wr_data;
            end
        end
    end
`else
    assign rd_word = bram_rd_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= PTR_INIT;
            s1_vld_reg   <= 1'b0;
            s1_tag_reg   <= '0;
            rsp_vld_reg  <= '0;
            rsp_data_reg <= '0;
        end else begin
            s1_vld_reg  <= grant;
            rsp_vld_reg <= rsp_vld_next;
            if (grant) begin
                s1_tag_reg <= gnt_idx;
                ptr_reg    <= gnt_idx;
            end
            if (s1_vld_reg) begin
                rsp_data_reg <= rd_word;
            end
        end
    end

    assign rsp_vld  = rsp_vld_reg;
    assign rsp_data = rsp_data_reg;
    assign busy     = s1_vld_reg | (|rsp_vld_reg);

endmodule

// File: doc/bram_rd_arbiter.md
Name: bram_rd_arbiter

Overview:
- Shares the single read port of one input BRAM (192b x 2048) among NUM_REQ node-evaluation requesters.
- Arbitration is round-robin; one grant per cycle at full throughput.
- The block tracks BRAM read latency and returns each read word to the requester that issued it.
- It also owns the BRAM write port as a registered-free pass-through from the loader, and sits between the node engines and the BRAM instance.

Parameters:
- NUM_REQ, 4, number of read requesters (2..8)
- ADDR_WIDTH, 11, BRAM address width
- DATA_WIDTH, 192, BRAM word width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- arb_en  in  1  global enable; 0 = no new grants
- req_vld  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_rdy  out  NUM_REQ  one-hot grant, combinational
- rsp_vld  out  NUM_REQ  one-hot response valid, registered
- rsp_data  out  DATA_WIDTH  response word shared by all requesters, registered
- busy  out  1  a read is in flight in stage 1 or stage 2
- wr_vld  in  1  loader write request
- wr_addr  in  ADDR_WIDTH  loader write address
- wr_data  in  DATA_WIDTH  loader write data
- bram_re  out  1  BRAM read enable
- bram_rd_addr  out  ADDR_WIDTH  BRAM read address
- bram_rd_data  in  DATA_WIDTH  BRAM read data, valid 1 cycle after bram_re
- bram_we  out  1  BRAM write enable (= wr_vld)
- bram_wr_addr  out  ADDR_WIDTH  (= wr_addr)
- bram_wr_data  out  DATA_WIDTH  (= wr_data)

Behaviour:
- Reset (async, rst_n=0):
  - rsp_vld=0, rsp_data=0, busy=0.
  - Stage-1 valid/tag cleared.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - req_rdy=0 and bram_re=0 while rst_n=0.
- Arbitration, combinational in cycle N:
  - If arb_en=1 and any req_vld, grant the first requester with req_vld set, searching from ptr+1 with modulo NUM_REQ wrap.
  - req_rdy[g]=1 (one-hot), bram_re=1, bram_rd_addr=req_addr[g].
  - Otherwise req_rdy=0, bram_re=0, bram_rd_addr=0.
  - A transfer occurs when req_vld[i]&req_rdy[i]. The requester holds its address until it is granted; req_rdy never depends on anything except req_vld, arb_en and ptr.
- Pointer:
  - ptr <= g on a grant.
  - ptr is unchanged when there is no grant or arb_en=0.
- Pipeline:
  - Stage 1, edge ending N: s1_vld<=grant, s1_tag<=g.
  - Stage 2, edge ending N+1: rsp_vld<=s1_vld ? onehot(s1_tag) : 0, rsp_data<=bram_rd_data when s1_vld.
  - rsp_data holds its last value otherwise.
  - Latency: grant in cycle N -> rsp_vld visible in cycle N+2, exactly 1 cycle wide.
  - Throughput: 1 read/cycle, back-to-back, no bubbles.
- Responses have no backpressure; requesters must accept rsp in the cycle it is valid.
- busy = s1_vld | (|rsp_vld).
- arb_en falling: in-flight reads complete normally, with no new grants. Rising: arbitration resumes from the current ptr.
- Writes pass straight through and never block reads. Read and write may target any addresses in the same cycle.
- Same-address read/write collision in one cycle: the BRAM returns the pre-write word (read-first). See the optional feature.
- rst_n asserted mid-operation: in-flight reads are discarded with no rsp_vld. After release, the first grant goes to the lowest-index active requester.
- Only requester index g (log2 NUM_REQ bits) is stored. Address widths are passed unmodified; no arithmetic on addresses.

Optional Feature:
- Macro: BRAM_RD_WR_FWD_EN.
- Defined:
  - In a grant cycle where wr_vld=1 and wr_addr==bram_rd_addr, stage 1 also registers fwd<=1 and fwd_data<=wr_data.
  - Stage 2 then selects fwd_data instead of bram_rd_data, so the response is the newly written word (write-first semantics).
  - Adds one DATA_WIDTH register and one comparator.
- Undefined: no forwarding logic; a collision returns the old BRAM contents.

Test Plan:
- Reset with all req_vld=1 -> first grant req_rdy=4'b0001. Grants then go 0,1,2,3,0 in successive cycles; each rsp_vld appears 2 cycles after its grant with the matching preloaded word.
- Only requester 2 active, addr 0x005, mem[5]=0xA5..A5 -> req_rdy=4'b0100 every cycle. rsp_vld=4'b0100 every cycle from the 3rd cycle, rsp_data=0xA5..A5.
- Requesters 1 and 3 active, arb_en low for 3 cycles mid-stream -> no req_rdy during the low window. Pending rsp_vld still drains; busy falls to 0. Arbitration resumes with the requester after the last granted one.
- Same cycle: write addr 0x010 := 0x1234 (old value 0xFFFF) and grant read of 0x010 -> rsp_data=0xFFFF without BRAM_RD_WR_FWD_EN, 0x1234 with it.
- rst_n pulsed low one cycle after a grant to requester 1 -> rsp_vld stays 0, ptr reset. The next grant goes to requester 0 if it is active.
